// File: rtl/button_event_arbiter_if.sv
// Event stream from the button arbiter to the game FSM: valid/ready handshake
// plus per-button pending status.
interface button_event_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
);
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic           evt_repeat;
  logic [N-1:0]   pending;

  modport master (output evt_valid, evt_id, evt_repeat, pending, input evt_ready);
  modport slave  (input evt_valid, evt_id, evt_repeat, pending, output evt_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into press / auto-repeat events, shared
// round-robin on a single valid/ready output slot.
module button_event_arbiter #(
  parameter int unsigned N             = 4,
  parameter int unsigned IDW           = 2,
  parameter int unsigned CNT_W         = 25,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           btn_level,
  button_event_arbiter_if.master evt
);
  localparam logic [CNT_W-1:0] DELAY    = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [IDW-1:0]   LAST_RST = IDW'(N - 1);

  logic [N-1:0]     prev_q, prev_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic             valid_q, valid_d;
  logic             repeat_q, repeat_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   last_q, last_d;

  logic [N-1:0]     rise, fire, grant;
  logic             slot_free, found_hi, found_lo;
  int unsigned      pick_hi, pick_lo, pick;

  always_comb begin
    prev_d = btn_level;
    rise   = btn_level & ~prev_q;
    fire   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!btn_level[i])
        cnt_d[i] = '0;
      else if (rise[i])
        cnt_d[i] = ONE;
      else if (REPEAT_DELAY != 0 && cnt_q[i] == DELAY) begin
        fire[i]  = 1'b1;
        cnt_d[i] = RELOAD;
      end else if (cnt_q[i] != '1)
        cnt_d[i] = cnt_q[i] + ONE;
    end
  end

  // Rotating scan from last_q+1 done as two fixed scans: first pending index
  // above last_q, else the lowest pending index overall.
  always_comb begin
    slot_free = !valid_q || evt.evt_ready;
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    pick_hi   = 0;
    pick_lo   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_hi && pend_q[i] && i > int'(last_q)) begin
        found_hi = 1'b1;
        pick_hi  = i;
      end
      if (!found_lo && pend_q[i]) begin
        found_lo = 1'b1;
        pick_lo  = i;
      end
    end
    pick = found_hi ? pick_hi : pick_lo;

    grant    = '0;
    valid_d  = valid_q;
    id_d     = id_q;
    repeat_d = repeat_q;
    last_d   = last_q;
    if (slot_free) begin
      valid_d = found_lo;
      for (int unsigned i = 0; i < N; i++) begin
        if (found_lo && i == pick) begin
          grant[i] = 1'b1;
          id_d     = IDW'(i);
          last_d   = IDW'(i);
          repeat_d = rep_q[i];
        end
      end
    end

    // A new request in the grant cycle survives the clear.
    pend_d = (pend_q & ~grant) | rise | fire;
    rep_d  = (rep_q & ~rise) | fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      pend_q   <= '0;
      rep_q    <= '0;
      valid_q  <= 1'b0;
      repeat_q <= 1'b0;
      id_q     <= '0;
      last_q   <= LAST_RST;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      rep_q    <= rep_d;
      valid_q  <= valid_d;
      repeat_q <= repeat_d;
      id_q     <= id_d;
      last_q   <= last_d;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign evt.evt_valid  = valid_q;
  assign evt.evt_id     = id_q;
  assign evt.evt_repeat = repeat_q;
  assign evt.pending    = pend_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios plus randomized traffic
// against a behavioural model based on hold age since press.
module tb_button_event_arbiter;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int D = 10;
  localparam int P = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_level;
  int           n_checks;
  int           n_fail;

  button_event_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  button_event_arbiter #(
    .N(N), .IDW(IDW), .CNT_W(8), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_level(btn_level), .evt(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: events fire on press and whenever hold age reaches D, D+P, D+2P...
  bit [N-1:0] m_prev, m_pend, m_rep;
  int         m_age [N];
  bit         m_valid, m_rep_o;
  int         m_id, m_last;

  always @(posedge clk or negedge rst_n) begin : model
    int  pick;
    bit  found;
    if (!rst_n) begin
      m_prev = '0; m_pend = '0; m_rep = '0;
      m_valid = 0; m_rep_o = 0; m_id = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) m_age[i] = 0;
    end else begin
      if (!m_valid || bus.evt_ready) begin
        found = 0;
        pick  = 0;
        for (int k = 1; k <= N; k++)
          if (!found && m_pend[(m_last + k) % N]) begin
            found = 1;
            pick  = (m_last + k) % N;
          end
        m_valid = found;
        if (found) begin
          m_id = pick; m_rep_o = m_rep[pick]; m_pend[pick] = 0; m_last = pick;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!btn_level[i]) m_age[i] = 0;
        else if (!m_prev[i]) begin
          m_age[i] = 0; m_pend[i] = 1; m_rep[i] = 0;
        end else begin
          m_age[i]++;
          if (m_age[i] >= D && (m_age[i] - D) % P == 0) begin
            m_pend[i] = 1; m_rep[i] = 1;
          end
        end
      end
      m_prev = btn_level;
    end
  end

  task automatic do_reset();
    btn_level = '0;
    bus.evt_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.evt_valid, bus.evt_id, bus.evt_repeat, bus.pending} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b id=%0d r=%b pend=%b expected all zero",
               bus.evt_valid, bus.evt_id, bus.evt_repeat, bus.pending);
    end
  endtask

  task automatic test_single_press();
    int events = 0;
    do_reset();
    bus.evt_ready = 1'b1;
    @(negedge clk);
    btn_level = 4'b0100;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.evt_valid) begin
        events++;
        n_checks++;
        if (c != 2 || bus.evt_id !== 2'd2 || bus.evt_repeat !== 1'b0) begin
          n_fail++;
          $display("FAIL single_press_event: got cycle=%0d id=%0d r=%b expected cycle=2 id=2 r=0",
                   c, bus.evt_id, bus.evt_repeat);
        end
      end
      if (c == 10) btn_level = '0;
    end
    n_checks++;
    if (events != 1) begin
      n_fail++;
      $display("FAIL single_press_count: got %0d events expected 1", events);
    end
  endtask

  task automatic test_simultaneous();
    bit       exp_v  [5] = '{0, 1, 1, 1, 0};
    int       exp_id [5] = '{0, 0, 1, 3, 0};
    do_reset();
    bus.evt_ready = 1'b1;
    @(negedge clk);
    btn_level = 4'b1011;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      btn_level = '0;
      n_checks++;
      if (bus.evt_valid !== exp_v[c-1] ||
          (exp_v[c-1] && (bus.evt_id !== 2'(exp_id[c-1]) || bus.evt_repeat !== 1'b0))) begin
        n_fail++;
        $display("FAIL simultaneous_c%0d: got v=%b id=%0d expected v=%b id=%0d",
                 c, bus.evt_valid, bus.evt_id, exp_v[c-1], exp_id[c-1]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [IDW-1:0] id;
    do_reset();
    @(negedge clk);
    btn_level = 4'b0011;
    @(negedge clk);
    btn_level = '0;
    @(negedge clk);
    for (int it = 0; it < 6; it++) begin
      n_checks++;
      if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'(it % 2)) begin
        n_fail++;
        $display("FAIL fairness_%0d: got v=%b id=%0d expected v=1 id=%0d",
                 it, bus.evt_valid, bus.evt_id, it % 2);
      end
      id = bus.evt_id;
      bus.evt_ready = 1'b1;
      btn_level = 4'b0001 << id;
      @(negedge clk);
      bus.evt_ready = 1'b0;
      btn_level = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit stable = 1;
    do_reset();
    @(negedge clk);
    btn_level = 4'b0110;
    @(negedge clk);
    btn_level = '0;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd1 || bus.evt_repeat !== 1'b0)
        stable = 0;
      @(negedge clk);
    end
    n_checks++;
    if (!stable || bus.evt_id !== 2'd1 || bus.pending !== 4'b0100) begin
      n_fail++;
      $display("FAIL backpressure_hold: got stable=%b id=%0d pend=%b expected stable=1 id=1 pend=0100",
               stable, bus.evt_id, bus.pending);
    end
    bus.evt_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd2 || bus.pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL backpressure_next: got v=%b id=%0d pend=%b expected v=1 id=2 pend=0000",
               bus.evt_valid, bus.evt_id, bus.pending);
    end
    @(negedge clk);
    n_checks++;
    if (bus.evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_drain: got v=%b expected v=0", bus.evt_valid);
    end
  endtask

  task automatic test_autorepeat();
    bit exp_v;
    do_reset();
    bus.evt_ready = 1'b1;
    @(negedge clk);
    btn_level = 4'b1000;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      exp_v = (c == 2) || (c >= 12 && c <= 28 && (c - 12) % 4 == 0);
      n_checks++;
      if (bus.evt_valid !== exp_v ||
          (exp_v && (bus.evt_id !== 2'd3 || bus.evt_repeat !== (c != 2)))) begin
        n_fail++;
        $display("FAIL autorepeat_c%0d: got v=%b id=%0d r=%b expected v=%b id=3 r=%b",
                 c, bus.evt_valid, bus.evt_id, bus.evt_repeat, exp_v, c != 2);
      end
      if (c == 30) btn_level = '0;
    end
  endtask

  task automatic test_random();
    logic [7:0] obs, exp;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      obs = {bus.evt_valid, bus.evt_id, bus.evt_repeat, bus.pending};
      exp = {m_valid, 2'(m_id), m_rep_o, m_pend};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random_c%0d: got {v,id,r,pend}=%b expected %b", c, obs, exp);
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) btn_level[i] = ~btn_level[i];
      bus.evt_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    btn_level = 4'b1100;
    @(negedge clk);
    btn_level = '0;
    @(negedge clk);
    n_checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd2) begin
      n_fail++;
      $display("FAIL async_reset_pre: got v=%b id=%0d expected v=1 id=2", bus.evt_valid, bus.evt_id);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.evt_valid, bus.evt_id, bus.evt_repeat, bus.pending} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_clear: got v=%b id=%0d r=%b pend=%b expected all zero",
               bus.evt_valid, bus.evt_id, bus.evt_repeat, bus.pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.evt_ready = 1'b1;
    @(negedge clk);
    btn_level = 4'b1111;
    @(negedge clk);
    btn_level = '0;
    @(negedge clk);
    n_checks++;
    if (bus.evt_valid !== 1'b1 || bus.evt_id !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset_first_grant: got v=%b id=%0d expected v=1 id=0",
               bus.evt_valid, bus.evt_id);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    btn_level = '0;
    bus.evt_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_autorepeat();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
